// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer
// Configures the audio codec over the single-master I2C controller. After a
// power-up delay it issues one two-byte write ({reg, data}) per entry of an
// external combinational table. Once the table is exhausted it serves runtime
// register writes from a host port. This block owns the controller's enable,
// mode, address and byte inputs.
//
// Handshakes:
//   host_req/host_ack : host_req is a level held by the host until host_ack.
//                       host_reg/host_data are sampled in the cycle the request
//                       is accepted (IDLE, table finished, controller ready).
//                       host_ack pulses for one cycle once the STOP has
//                       completed. A host_req still high in the cycle after
//                       host_ack is a new request.
//   i2c_enable/ready  : a transaction is launched only while i2c_ready=1.
//                       Enable stays high across both bytes and drops after
//                       the second byte. The STOP is complete when i2c_ready
//                       returns high. The next byte is presented when i2c_wip
//                       falls, which is inside the controller's ACK window.
module i2c_init_sequencer #(
    parameter logic [6:0] DEV_ADDR       = 7'h1A,
    parameter int         NUM_ENTRIES    = 10,
    parameter int         IDX_W          = 5,
    parameter int         POWERUP_CYCLES = 1000,
    parameter int         GAP_CYCLES     = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [IDX_W-1:0] table_index,
    input  logic [15:0]      table_entry,
    input  logic             host_req,
    input  logic [7:0]       host_reg,
    input  logic [7:0]       host_data,
    output logic             host_ack,
    output logic             i2c_enable,
    output logic             i2c_mode,
    output logic [6:0]       i2c_addr,
    output logic [7:0]       i2c_byte,
    input  logic             i2c_ready,
    input  logic             i2c_wip,
    output logic             busy,
    output logic             init_done,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_PWRUP     = 3'd0,
        S_IDLE      = 3'd1,
        S_LAUNCH    = 3'd2,
        S_REG_BYTE  = 3'd3,
        S_DATA_BYTE = 3'd4,
        S_STOPPING  = 3'd5,
        S_GAP       = 3'd6
    } state_t;

    // One shared counter serves both the power-up wait and the inter-transaction gap.
    localparam int CNT_MAX_RAW = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX     = (CNT_MAX_RAW < 1) ? 1 : CNT_MAX_RAW;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             wip_q;
    logic             wip_fall;
    logic             launch_ok;
    logic [7:0]       cur_reg;
    logic [7:0]       cur_reg_nx;
    logic [7:0]       cur_data;
    logic [7:0]       cur_data_nx;
    logic             host_owned;
    logic             host_owned_nx;
    logic [IDX_W-1:0] table_index_nx;
    logic             init_done_nx;
    logic             i2c_enable_nx;
    logic [7:0]       i2c_byte_nx;
    logic             host_ack_nx;

    assign i2c_mode  = 1'b1;
    assign i2c_addr  = DEV_ADDR;
    assign state_dbg = state;

    // A byte has finished shifting when write-in-progress drops.
    assign wip_fall  = wip_q & ~i2c_wip;

    // The table has absolute priority; host requests wait until init is done.
    assign launch_ok = i2c_ready & (~init_done | host_req);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_PWRUP;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            S_PWRUP:     if (cnt == PWR_LAST) state_nx = S_IDLE;
            S_IDLE:      if (launch_ok)       state_nx = S_LAUNCH;
            S_LAUNCH:                         state_nx = S_REG_BYTE;
            S_REG_BYTE:  if (wip_fall)        state_nx = S_DATA_BYTE;
            S_DATA_BYTE: if (wip_fall)        state_nx = S_STOPPING;
            S_STOPPING:  if (i2c_ready)       state_nx = S_GAP;
            S_GAP:       if (cnt == GAP_LAST) state_nx = S_IDLE;
            default:                          state_nx = S_PWRUP;
        endcase
    end

    // Output decode: busy plus next values of the registered outputs and datapath
    always_comb begin
        busy           = 1'b0;
        cnt_nx         = '0;
        cur_reg_nx     = cur_reg;
        cur_data_nx    = cur_data;
        host_owned_nx  = host_owned;
        table_index_nx = table_index;
        init_done_nx   = init_done;
        i2c_enable_nx  = i2c_enable;
        i2c_byte_nx    = i2c_byte;
        host_ack_nx    = 1'b0;
        case (state)
            S_PWRUP: begin
                if (cnt != PWR_LAST) cnt_nx = cnt + CNT_W'(1);
            end
            S_IDLE: begin
                if (launch_ok) begin
                    if (!init_done) begin
                        cur_reg_nx    = table_entry[15:8];
                        cur_data_nx   = table_entry[7:0];
                        host_owned_nx = 1'b0;
                    end else begin
                        cur_reg_nx    = host_reg;
                        cur_data_nx   = host_data;
                        host_owned_nx = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                busy          = 1'b1;
                i2c_byte_nx   = cur_reg;
                i2c_enable_nx = 1'b1;
            end
            S_REG_BYTE: begin
                busy = 1'b1;
                if (wip_fall) i2c_byte_nx = cur_data;
            end
            S_DATA_BYTE: begin
                busy = 1'b1;
                if (wip_fall) i2c_enable_nx = 1'b0;
            end
            S_STOPPING: begin
                busy = 1'b1;
                if (i2c_ready) begin
                    if (host_owned) begin
                        host_ack_nx   = 1'b1;
                        host_owned_nx = 1'b0;
                    end else if (table_index == LAST_IDX) begin
                        init_done_nx  = 1'b1;
                    end else begin
                        table_index_nx = table_index + IDX_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (cnt != GAP_LAST) cnt_nx = cnt + CNT_W'(1);
            end
            default: begin
                cnt_nx = '0;
            end
        endcase
    end

    // Datapath, wip history and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            wip_q       <= 1'b0;
            cur_reg     <= 8'h00;
            cur_data    <= 8'h00;
            host_owned  <= 1'b0;
            table_index <= '0;
            init_done   <= 1'b0;
            i2c_enable  <= 1'b0;
            i2c_byte    <= 8'h00;
            host_ack    <= 1'b0;
        end else begin
            cnt         <= cnt_nx;
            wip_q       <= i2c_wip;
            cur_reg     <= cur_reg_nx;
            cur_data    <= cur_data_nx;
            host_owned  <= host_owned_nx;
            table_index <= table_index_nx;
            init_done   <= init_done_nx;
            i2c_enable  <= i2c_enable_nx;
            i2c_byte    <= i2c_byte_nx;
            host_ack    <= host_ack_nx;
        end
    end

endmodule
